// File: rtl/dac_wave_gen_if.sv
// DAC waveform generator bus: trigger/control inputs, limits and DAC code outputs.
// master drives enable/trigger/restart/mode/step/min_val/max_val; slave returns dac_val/dir/wrap/done/cfg_err.
interface dac_wave_gen_if #(
    parameter int PRECISION = 12
);
    logic                 enable;
    logic                 trigger;
    logic                 restart;
    logic [1:0]           mode;
    logic [PRECISION-1:0] step;
    logic [PRECISION-1:0] min_val;
    logic [PRECISION-1:0] max_val;
    logic [PRECISION-1:0] dac_val;
    logic                 dir;
    logic                 wrap;
    logic                 done;
    logic                 cfg_err;

    modport master (
        output enable, trigger, restart, mode, step, min_val, max_val,
        input  dac_val, dir, wrap, done, cfg_err
    );

    modport slave (
        input  enable, trigger, restart, mode, step, min_val, max_val,
        output dac_val, dir, wrap, done, cfg_err
    );
endinterface

// File: rtl/dac_wave_gen.sv
// DAC code generator: saw up/down, triangle and single-shot ramps, one step per trigger edge.
// Ports: clk, reset (async, active-high), bus (slave modport of dac_wave_gen_if).
module dac_wave_gen #(
    parameter int PRECISION = 12
) (
    input logic           clk,
    input logic           reset,
    dac_wave_gen_if.slave bus
);
    localparam int W = PRECISION + 1;

    typedef enum logic [1:0] {
        M_UP  = 2'b00,
        M_DN  = 2'b01,
        M_TRI = 2'b10,
        M_ONE = 2'b11
    } mode_e;

    mode_e mode_w;

    logic s1_q, s2_q, s3_q;
    logic evt, qual;

    logic [PRECISION-1:0] dac_q, dac_d;
    logic dir_q, dir_d;
    logic wrap_q, wrap_d;
    logic done_q, done_d;

    logic [W-1:0] sum, diff, min_x, max_x;
    logic         under;
    logic [PRECISION-1:0] start_val;
    logic         start_dir;
    logic         out_of_range;

    assign mode_w = mode_e'(bus.mode);

    assign bus.cfg_err = (bus.min_val > bus.max_val);

    // Rising edge seen on the 2nd/3rd synchroniser stages
    assign evt  = s2_q & ~s3_q;
    assign qual = evt & bus.enable & ~bus.cfg_err & ~bus.restart;

    assign min_x = {1'b0, bus.min_val};
    assign max_x = {1'b0, bus.max_val};
    assign sum   = {1'b0, dac_q} + {1'b0, bus.step};
    assign diff  = {1'b0, dac_q} - {1'b0, bus.step};
    // Borrow out of the extended subtraction means step > dac_q
    assign under = diff[PRECISION];

    assign start_dir    = (mode_w != M_DN);
    assign start_val    = start_dir ? bus.min_val : bus.max_val;
    assign out_of_range = (dac_q < bus.min_val) || (dac_q > bus.max_val);

    always_comb begin
        dac_d  = dac_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        done_d = done_q;
        if (bus.restart) begin
            dac_d  = start_val;
            dir_d  = start_dir;
            done_d = 1'b0;
        end else if (qual) begin
            if (out_of_range) begin
                dac_d = start_val;
                dir_d = start_dir;
            end else begin
                case (mode_w)
                    M_UP: begin
                        dir_d = 1'b1;
                        if (sum > max_x) begin
                            dac_d  = bus.min_val;
                            wrap_d = 1'b1;
                        end else begin
                            dac_d = sum[PRECISION-1:0];
                        end
                    end
                    M_DN: begin
                        dir_d = 1'b0;
                        if (under || (diff < min_x)) begin
                            dac_d  = bus.max_val;
                            wrap_d = 1'b1;
                        end else begin
                            dac_d = diff[PRECISION-1:0];
                        end
                    end
                    M_TRI: begin
                        // step=0 must not flip direction at a limit
                        if (bus.step != '0) begin
                            if (dir_q) begin
                                if (sum >= max_x) begin
                                    dac_d = bus.max_val;
                                    dir_d = 1'b0;
                                end else begin
                                    dac_d = sum[PRECISION-1:0];
                                end
                            end else begin
                                if (under || (diff <= min_x)) begin
                                    dac_d  = bus.min_val;
                                    dir_d  = 1'b1;
                                    wrap_d = 1'b1;
                                end else begin
                                    dac_d = diff[PRECISION-1:0];
                                end
                            end
                        end
                    end
                    M_ONE: begin
                        dir_d = 1'b1;
                        if (!done_q) begin
                            if (sum >= max_x) begin
                                dac_d  = bus.max_val;
                                done_d = 1'b1;
                            end else begin
                                dac_d = sum[PRECISION-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            dac_q  <= '0;
            dir_q  <= 1'b1;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            s1_q   <= bus.trigger;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            dac_q  <= dac_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign bus.dac_val = dac_q;
    assign bus.dir     = dir_q;
    assign bus.wrap    = wrap_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_dac_wave_gen.sv
// Bench for dac_wave_gen: directed ramps plus random traffic against a reference model.
// Expected outputs are queued with their due cycle; a negedge monitor pops and compares.
module tb_dac_wave_gen;
    localparam int P = 12;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dac_wave_gen_if #(.PRECISION(P)) bus();

    dac_wave_gen #(.PRECISION(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int dac;
        bit dir;
        bit wrap;
        bit done;
    } exp_t;

    exp_t q[$];
    exp_t vis;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference model state and configuration
    int mv, mmin, mmax, mstep, mmode;
    bit mdir, mdone, men;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("timeout", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("dac_val", int'(bus.dac_val), e.dac);
                chk("dir", int'(bus.dir), int'(e.dir));
                chk("wrap", int'(bus.wrap), int'(e.wrap));
                chk("done", int'(bus.done), int'(e.done));
                vis = e;
            end else begin
                chk("dac_hold", int'(bus.dac_val), vis.dac);
                chk("dir_hold", int'(bus.dir), int'(vis.dir));
                chk("wrap_idle", int'(bus.wrap), 0);
                chk("done_hold", int'(bus.done), int'(vis.done));
            end
        end
    end

    function automatic void m_start();
        if (mmode == 1) begin
            mv   = mmax;
            mdir = 1'b0;
        end else begin
            mv   = mmin;
            mdir = 1'b1;
        end
    endfunction

    function automatic bit m_event();
        bit w = 1'b0;
        if (!men || mmin > mmax) return 1'b0;
        if (mv < mmin || mv > mmax) begin
            m_start();
            return 1'b0;
        end
        case (mmode)
            0: begin
                mdir = 1'b1;
                if (mv + mstep > mmax) begin
                    mv = mmin;
                    w  = 1'b1;
                end else mv = mv + mstep;
            end
            1: begin
                mdir = 1'b0;
                if (mv - mstep < mmin) begin
                    mv = mmax;
                    w  = 1'b1;
                end else mv = mv - mstep;
            end
            2: begin
                if (mstep != 0) begin
                    if (mdir) begin
                        if (mv + mstep >= mmax) begin
                            mv   = mmax;
                            mdir = 1'b0;
                        end else mv = mv + mstep;
                    end else begin
                        if (mv - mstep <= mmin) begin
                            mv   = mmin;
                            mdir = 1'b1;
                            w    = 1'b1;
                        end else mv = mv - mstep;
                    end
                end
            end
            default: begin
                mdir = 1'b1;
                if (!mdone) begin
                    if (mv + mstep >= mmax) begin
                        mv    = mmax;
                        mdone = 1'b1;
                    end else mv = mv + mstep;
                end
            end
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int due, bit w);
        exp_t e;
        e.due  = due;
        e.dac  = mv;
        e.dir  = mdir;
        e.wrap = w;
        e.done = mdone;
        q.push_back(e);
    endtask

    task automatic cfg(int md, int mn, int mx, int st, bit en);
        bus.mode    = 2'(md);
        bus.min_val = P'(mn);
        bus.max_val = P'(mx);
        bus.step    = P'(st);
        bus.enable  = en;
        mmode = md;
        mmin  = mn;
        mmax  = mx;
        mstep = st;
        men   = en;
        #1;
        chk("cfg_err", int'(bus.cfg_err), int'(mn > mx));
    endtask

    task automatic trig();
        bit w;
        bus.trigger = 1'b1;
        w = m_event();
        push(cyc + 3, w);
        tick();
        bus.trigger = 1'b0;
        repeat (3) tick();
    endtask

    task automatic rst_pulse();
        bus.restart = 1'b1;
        m_start();
        mdone = 1'b0;
        push(cyc + 1, 1'b0);
        tick();
        bus.restart = 1'b0;
        tick();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b1;
        bus.trigger = 1'b0;
        bus.restart = 1'b0;
        bus.mode    = 2'b00;
        bus.step    = '0;
        bus.min_val = '0;
        bus.max_val = '0;
        mv = 0; mdir = 1'b1; mdone = 1'b0;
        mmin = 0; mmax = 0; mstep = 0; mmode = 0; men = 1'b1;
        #12;
        tick();
        chk("rst_dac", int'(bus.dac_val), 0);
        chk("rst_dir", int'(bus.dir), 1);
        chk("rst_wrap", int'(bus.wrap), 0);
        chk("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        tick();
        vis = '{0, 0, 1'b1, 1'b0, 1'b0};
        mon_on = 1'b1;

        // Full-scale saw up with wrap on the 4096th trigger
        cfg(0, 0, 4095, 1, 1'b1);
        rst_pulse();
        repeat (4096) trig();
        chk("full_saw_end", int'(bus.dac_val), 0);

        cfg(0, 100, 200, 30, 1'b1);
        rst_pulse();
        repeat (4) trig();
        chk("saw_up_end", int'(bus.dac_val), 100);

        cfg(1, 0, 50, 20, 1'b1);
        rst_pulse();
        repeat (3) trig();
        chk("saw_dn_end", int'(bus.dac_val), 50);

        cfg(2, 0, 10, 4, 1'b1);
        rst_pulse();
        repeat (7) trig();
        chk("tri_end", int'(bus.dac_val), 4);
        chk("tri_dir", int'(bus.dir), 1);

        cfg(3, 0, 20, 8, 1'b1);
        rst_pulse();
        repeat (6) trig();
        chk("one_end", int'(bus.dac_val), 20);
        chk("one_done", int'(bus.done), 1);
        rst_pulse();
        chk("one_rst_done", int'(bus.done), 0);

        // Disabled triggers are dropped
        cfg(0, 0, 100, 5, 1'b1);
        rst_pulse();
        trig();
        cfg(0, 0, 100, 5, 1'b0);
        repeat (3) trig();
        chk("en_off_hold", int'(bus.dac_val), 5);
        cfg(0, 0, 100, 5, 1'b1);
        trig();
        chk("en_on_step", int'(bus.dac_val), 10);

        // Restart coinciding with a live event
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        tick();
        bus.restart = 1'b1;
        m_start();
        mdone = 1'b0;
        push(cyc + 1, 1'b0);
        tick();
        bus.restart = 1'b0;
        repeat (2) tick();
        chk("restart_wins", int'(bus.dac_val), 0);

        // Inverted limits
        cfg(0, 300, 200, 5, 1'b1);
        repeat (2) trig();
        chk("cfg_err_hold", int'(bus.dac_val), 0);
        rst_pulse();
        chk("cfg_err_restart", int'(bus.dac_val), 300);

        // Reset mid-ramp with a trigger in flight
        cfg(3, 0, 1234, 1234, 1'b1);
        rst_pulse();
        trig();
        chk("pre_rst_dac", int'(bus.dac_val), 1234);
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        #2;
        mon_on = 1'b0;
        reset  = 1'b1;
        #1;
        chk("async_rst_dac", int'(bus.dac_val), 0);
        chk("async_rst_dir", int'(bus.dir), 1);
        chk("async_rst_done", int'(bus.done), 0);
        tick();
        reset = 1'b0;
        mv = 0; mdir = 1'b1; mdone = 1'b0;
        vis = '{0, 0, 1'b1, 1'b0, 1'b0};
        mon_on = 1'b1;
        repeat (6) tick();
        chk("lost_trigger", int'(bus.dac_val), 0);

        // Range guard after raising min_val
        cfg(0, 500, 1000, 10, 1'b1);
        trig();
        chk("guard_load", int'(bus.dac_val), 500);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 12 == 0) begin
                int a, b, k, s, mn, mx, st;
                a = int'($urandom_range(0, 4095));
                b = int'($urandom_range(0, 4095));
                k = int'($urandom_range(0, 7));
                s = int'($urandom_range(0, 7));
                if (k == 0) begin
                    mn = a; mx = a;
                end else if (k == 1) begin
                    mn = a; mx = b;
                end else begin
                    mn = (a < b) ? a : b;
                    mx = (a < b) ? b : a;
                end
                if (s == 0) st = 0;
                else if (s == 1) st = int'($urandom_range(0, 4095));
                else st = int'($urandom_range(1, 400));
                cfg(int'($urandom_range(0, 3)), mn, mx, st,
                    ($urandom_range(0, 7) != 0));
            end
            if ($urandom_range(0, 9) == 0) rst_pulse();
            else trig();
        end

        repeat (4) tick();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dac_wave_gen.md
Name: dac_wave_gen

Overview:
- Clocked, parametrised DAC code generator. Produces sawtooth-up, sawtooth-down, triangle and single-shot ramps.
- Advances one step per synchronised trigger edge.
- Step size and min/max limits are programmable.
- Sits between the trigger source (timer or external pin) and the DAC data bus. Supersedes the fixed +1 free-wrapping ramp counter.

Parameters:
- PRECISION, 12, width of the DAC code and of the step/min/max inputs.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  1 = trigger events are acted on; 0 = events are discarded (not queued).
- trigger  input  1  asynchronous step request; the rising edge is the event.
- restart  input  1  synchronous; loads the mode's start value.
- mode  input  2  00 saw up, 01 saw down, 10 triangle, 11 single-shot up.
- step  input  PRECISION  increment/decrement per event.
- min_val  input  PRECISION  lower limit, inclusive.
- max_val  input  PRECISION  upper limit, inclusive.
- dac_val  output  PRECISION  registered DAC code.
- dir  output  1  registered; 1 = ramping up, 0 = ramping down.
- wrap  output  1  registered one-cycle pulse marking a period boundary.
- done  output  1  registered; single-shot complete.
- cfg_err  output  1  combinational; high when min_val > max_val.

Behaviour:
- Reset values: dac_val=0, dir=1, wrap=0, done=0, synchroniser flops=0.
- Trigger path:
  - Chain s1<=trigger, s2<=s1, s3<=s2; event = s2 & ~s3.
  - dac_val updates on the 3rd rising clk edge after trigger is first sampled high.
  - One event per rising edge; a level held high gives one step.
- Event qualified = event & enable & ~cfg_err & ~restart. Unqualified events are dropped.
- restart (any cycle, wins over a simultaneous event):
  - modes 00, 10, 11: dac_val<=min_val, dir<=1.
  - mode 01: dac_val<=max_val, dir<=0.
  - Always: done<=0, wrap<=0.
  - restart while cfg_err is high: still loads.
- Range guard: on a qualified event with dac_val < min_val or dac_val > max_val (e.g. after reset or a limit change), load the start value as for restart. No wrap pulse; done is unchanged.
- Arithmetic: sums and differences are computed PRECISION+1 bits wide, so overflow and underflow are never silently truncated.
- Per qualified event, in range:
  - 00 saw up: sum=dac_val+step. If sum > max_val: dac_val<=min_val, wrap<=1. Else dac_val<=sum, so max_val itself is reachable exactly.
  - 01 saw down: diff=dac_val-step. If diff < min_val or it underflows: dac_val<=max_val, wrap<=1. Else dac_val<=diff.
  - 10 triangle, dir=1: if sum >= max_val then dac_val<=max_val, dir<=0; else dac_val<=sum. Clamp, no fold-back.
  - 10 triangle, dir=0: if diff <= min_val or it underflows then dac_val<=min_val, dir<=1, wrap<=1; else dac_val<=diff.
  - 11 single-shot: if done=1, hold. Else if sum >= max_val then dac_val<=max_val, done<=1; else dac_val<=sum.
- step=0: dac_val holds; no wrap, no dir change, done not set. Exception: a single-shot already at max_val sets done.
- min_val==max_val: dac_val stays at that value.
  - Saw modes pulse wrap every event when step>0.
  - Triangle reaches max, then min, alternating dir; wrap on each arrival at min.
- Mode change: no implicit restart. The new mode applies from the next qualified event, starting from the current dac_val and dir. dir is forced to 0 for mode 01 and 1 for modes 00 and 11 on their first event.
- wrap is high for exactly one cycle per wrapping event; otherwise 0.
- done clears only on restart or reset; it is not cleared by a mode change.
- Reset mid-ramp: outputs clear asynchronously with no clock edge needed. A trigger edge in flight in the synchroniser is lost.

Test Plan:
- Saw up, min=0, max=4095, step=1, restart, then 4096 triggers -> dac_val 1..4095, then 0 with a single-cycle wrap on the 4096th trigger; each update exactly 3 clk edges after the trigger rise.
- Saw up, min=100, max=200, step=30 -> 130, 160, 190, 100 (wrap=1). Saw down, min=0, max=50, step=20 -> restart 50, then 30, 10, 50 (wrap=1).
- Triangle, min=0, max=10, step=4, restart -> 4, 8, 10 (dir=0), 6, 2, 0 (dir=1, wrap=1), 4.
- Single-shot, min=0, max=20, step=8 -> 8, 16, 20 with done=1; 3 more triggers hold 20; restart -> dac_val=0, done=0.
- Qualification and limits:
  - enable=0 across 3 triggers -> dac_val unchanged.
  - restart coinciding with an event -> dac_val=min_val only.
  - min_val=300, max_val=200 -> cfg_err=1 and triggers ignored.
  - Reset dac_val=0, then set min=500 -> first trigger loads 500 with no wrap.
- Assert reset asynchronously mid-ramp at dac_val=1234 between clk edges -> dac_val=0, dir=1, done=0 immediately; a trigger issued 1 cycle before reset produces no step.
